// File: rtl/alu_pkg.sv
// Shared constants and types for the bit-serial ALU sequencer.
package alu_pkg;

    // ALU_control operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Operation select of the external 1-bit slice
    localparam logic [1:0] SOP_AND  = 2'b00;
    localparam logic [1:0] SOP_OR   = 2'b01;
    localparam logic [1:0] SOP_ADD  = 2'b10;
    localparam logic [1:0] SOP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SLT_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Decoded slice control for one operation
    typedef struct packed {
        logic [1:0] op;     // slice op for the (first) serial pass
        logic       a_inv;
        logic       b_inv;  // also the initial carry-in
        logic       slt;    // needs a second LESS pass
        logic       arith;  // ADD/SUB: cout and overflow are meaningful
        logic       valid;
    } slice_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALU_control into slice control fields.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [3:0]  alu_control_i,
    output slice_ctrl_t ctrl_o
);

    // Map each operation code to its slice op and inversion settings
    always_comb begin
        // NOTE: a full default before the case means no path leaves ctrl_o unassigned, so no latch.
        ctrl_o = '0;
        unique case (alu_control_i)
            ALU_AND: begin ctrl_o.op = SOP_AND; ctrl_o.valid = 1'b1; end
            ALU_OR:  begin ctrl_o.op = SOP_OR;  ctrl_o.valid = 1'b1; end
            ALU_ADD: begin
                ctrl_o.op    = SOP_ADD;
                ctrl_o.arith = 1'b1;
                ctrl_o.valid = 1'b1;
            end
            ALU_SUB: begin
                ctrl_o.op    = SOP_ADD;
                ctrl_o.b_inv = 1'b1;
                ctrl_o.arith = 1'b1;
                ctrl_o.valid = 1'b1;
            end
            ALU_NOR: begin
                ctrl_o.op    = SOP_AND;
                ctrl_o.a_inv = 1'b1;
                ctrl_o.b_inv = 1'b1;
                ctrl_o.valid = 1'b1;
            end
            ALU_SLT: begin
                ctrl_o.op    = SOP_ADD;
                ctrl_o.b_inv = 1'b1;
                ctrl_o.slt   = 1'b1;
                ctrl_o.valid = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, LSB first,
// with carry fed back between bits and a second pass for SLT.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ALU_control_i,
    output logic             slice_src1_o,
    output logic             slice_src2_o,
    output logic             slice_less_o,
    output logic             slice_A_invert_o,
    output logic             slice_B_invert_o,
    output logic             slice_cin_o,
    output logic [1:0]       slice_operation_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    slice_ctrl_t dec;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             set_q, set_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             a_inv_q, a_inv_d;
    logic             b_inv_q, b_inv_d;
    logic             slt_q, slt_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             last_bit;

    alu_ctrl_decode u_decode (
        .alu_control_i (ALU_control_i),
        .ctrl_o        (dec)
    );

    assign last_bit = (idx_q == LAST_IDX);

    // Next-state, datapath updates and slice drive for the serial FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        set_d   = set_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        a_inv_d = a_inv_q;
        b_inv_d = b_inv_q;
        slt_d   = slt_q;
        arith_d = arith_q;
        acc_d   = acc_q;
        result_d = result_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        slice_src1_o      = 1'b0;
        slice_src2_o      = 1'b0;
        slice_less_o      = 1'b0;
        slice_A_invert_o  = 1'b0;
        slice_B_invert_o  = 1'b0;
        slice_cin_o       = 1'b0;
        slice_operation_o = SOP_AND;
        busy_o            = 1'b0;
        done_o            = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    op_d    = dec.op;
                    a_inv_d = dec.a_inv;
                    b_inv_d = dec.b_inv;
                    slt_d   = dec.slt;
                    arith_d = dec.arith;
                    idx_d   = '0;
                    carry_d = dec.b_inv;
                    acc_d   = '0;
                    if (dec.valid) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = '0;
                        zero_d   = 1'b1;
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                busy_o            = 1'b1;
                slice_src1_o      = a_q[idx_q];
                slice_src2_o      = b_q[idx_q];
                slice_cin_o       = carry_q;
                slice_operation_o = op_q;
                slice_A_invert_o  = a_inv_q;
                slice_B_invert_o  = b_inv_q;
                carry_d           = slice_cout_i;
                idx_d             = idx_q + IDX_W'(1);
                // The SLT subtraction pass only produces the sign decision
                if (!slt_q) begin
                    acc_d[idx_q] = slice_result_i;
                end
                if (last_bit) begin
                    idx_d = '0;
                    if (slt_q) begin
                        state_d = ST_SLT_RUN;
                        carry_d = 1'b1;
                        // sign of A-B corrected by signed overflow at the MSB
                        set_d   = slice_result_i ^ (carry_q ^ slice_cout_i);
                    end else begin
                        state_d  = ST_DONE;
                        result_d = acc_d;
                        zero_d   = (acc_d == '0);
                        cout_d   = arith_q & slice_cout_i;
                        ovf_d    = arith_q & (carry_q ^ slice_cout_i);
                    end
                end
            end

            ST_SLT_RUN: begin
                busy_o            = 1'b1;
                slice_src1_o      = a_q[idx_q];
                slice_src2_o      = b_q[idx_q];
                slice_cin_o       = carry_q;
                slice_operation_o = SOP_LESS;
                slice_A_invert_o  = 1'b0;
                slice_B_invert_o  = 1'b1;
                slice_less_o      = (idx_q == '0) ? set_q : 1'b0;
                carry_d           = slice_cout_i;
                idx_d             = idx_q + IDX_W'(1);
                acc_d[idx_q]      = slice_result_i;
                if (last_bit) begin
                    idx_d    = '0;
                    state_d  = ST_DONE;
                    result_d = acc_d;
                    zero_d   = (acc_d == '0);
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end

            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: every register here, accumulator included, is plain flops, so all of it is reset; reset outranks start_i.
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            set_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= SOP_AND;
            a_inv_q  <= 1'b0;
            b_inv_q  <= 1'b0;
            slt_q    <= 1'b0;
            arith_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            set_q    <= set_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            a_inv_q  <= a_inv_d;
            b_inv_q  <= b_inv_d;
            slt_q    <= slt_d;
            arith_q  <= arith_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench: alu_serial_ctrl paired with a reference 1-bit slice.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int W       = 32;
    localparam int TIMEOUT = 2 * W + 8;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
    } exp_t;

    typedef struct {
        logic [3:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] src1, src2;
    logic [3:0]   alu_ctrl;
    logic         s_src1, s_src2, s_less, s_ainv, s_binv, s_cin;
    logic [1:0]   s_op;
    logic         s_result, s_cout;
    logic [W-1:0] result;
    logic         zero, cout, ovf, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .src1_i            (src1),
        .src2_i            (src2),
        .ALU_control_i     (alu_ctrl),
        .slice_src1_o      (s_src1),
        .slice_src2_o      (s_src2),
        .slice_less_o      (s_less),
        .slice_A_invert_o  (s_ainv),
        .slice_B_invert_o  (s_binv),
        .slice_cin_o       (s_cin),
        .slice_operation_o (s_op),
        .slice_result_i    (s_result),
        .slice_cout_i      (s_cout),
        .result_o          (result),
        .zero_o            (zero),
        .cout_o            (cout),
        .overflow_o        (ovf),
        .busy_o            (busy),
        .done_o            (done)
    );

    // Reference 1-bit ALU slice
    logic sa, sb;
    always_comb begin
        sa     = s_src1 ^ s_ainv;
        sb     = s_src2 ^ s_binv;
        s_cout = (sa & sb) | (sa & s_cin) | (sb & s_cin);
        case (s_op)
            2'b00:   s_result = sa & sb;
            2'b01:   s_result = sa | sb;
            2'b10:   s_result = sa ^ sb ^ s_cin;
            default: s_result = s_less;
        endcase
    end

    // Word-level reference model of the whole operation
    function automatic exp_t model(input logic [3:0] code, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e.r = '0; e.c = 1'b0; e.v = 1'b0; e.lat = W + 1;
        case (code)
            ALU_AND: e.r = a & b;
            ALU_OR:  e.r = a | b;
            ALU_NOR: e.r = ~(a | b);
            ALU_ADD: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                s   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            ALU_SLT: begin
                e.r   = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                e.lat = 2 * W + 1;
            end
            default: e.lat = 1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for done, compare everything visible
    task automatic run_check(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit hold, input exp_t e);
        int lat;
        bit seen;
        int extra;
        @(negedge clk);
        alu_ctrl = code; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            if (!hold) start = 1'b0;
            if (done) seen = 1'b1;
            else if (hold) begin
                src1 = $urandom; src2 = $urandom; alu_ctrl = 4'($urandom);
            end
        end
        check({tag, ".done_seen"}, 64'(seen), 64'(1));
        check({tag, ".latency"},   64'(lat), 64'(e.lat));
        check({tag, ".result"},    64'(result), 64'(e.r));
        check({tag, ".zero"},      64'(zero), 64'(e.z));
        check({tag, ".cout"},      64'(cout), 64'(e.c));
        check({tag, ".overflow"},  64'(ovf), 64'(e.v));
        check({tag, ".done_side"},
              64'({busy, s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}), 64'(0));
        @(negedge clk);
        start = 1'b0;
        check({tag, ".pulse_end"}, 64'({done, busy}), 64'(0));
        check({tag, ".held"},      64'(result), 64'(e.r));
        if (hold) begin
            extra = 0;
            repeat (2 * W + 4) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check({tag, ".no_requeue"}, 64'(extra), 64'(0));
        end
    endtask

    vec_t       vecs[11];
    logic [3:0] codes[7];

    initial begin
        int   n_done;
        exp_t e;

        vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b0, 1'b1, 33}};
        vecs[1]  = '{ALU_SUB, 32'h00000005, 32'h00000005, '{32'h00000000, 1'b1, 1'b1, 1'b0, 33}};
        vecs[2]  = '{ALU_SLT, 32'hFFFFFFFF, 32'h00000001, '{32'h00000001, 1'b0, 1'b0, 1'b0, 65}};
        vecs[3]  = '{ALU_SLT, 32'h00000001, 32'hFFFFFFFF, '{32'h00000000, 1'b1, 1'b0, 1'b0, 65}};
        vecs[4]  = '{ALU_NOR, 32'h0F0F0F0F, 32'h00FF00FF, '{32'hF000F000, 1'b0, 1'b0, 1'b0, 33}};
        vecs[5]  = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1}};
        vecs[6]  = '{ALU_AND, 32'hFFFF0000, 32'h0F0F0F0F, '{32'h0F0F0000, 1'b0, 1'b0, 1'b0, 33}};
        vecs[7]  = '{ALU_OR,  32'h12340000, 32'h00005678, '{32'h12345678, 1'b0, 1'b0, 1'b0, 33}};
        vecs[8]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b1, 1'b0, 33}};
        vecs[9]  = '{ALU_SUB, 32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 33}};
        vecs[10] = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, '{32'h00000001, 1'b0, 1'b0, 1'b0, 65}};

        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT, 4'b1010};

        // Reset with start asserted: reset wins, everything reads 0
        rst = 1'b1; start = 1'b1; alu_ctrl = ALU_ADD; src1 = 32'h1; src2 = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.result", 64'(result), 64'(0));
        check("reset.flags",  64'({zero, cout, ovf, busy, done}), 64'(0));
        check("reset.slice",  64'({s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}), 64'(0));
        start = 1'b0; rst = 1'b0;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, 1'b0, vecs[i].e);

        // start held high through RUN and DONE with operands wiggling
        run_check("hold", ALU_ADD, 32'h00001234, 32'h00004321, 1'b1,
                  model(ALU_ADD, 32'h00001234, 32'h00004321));

        // Reset around bit 10 aborts with no done pulse
        @(negedge clk);
        alu_ctrl = ALU_ADD; src1 = 32'hCAFE0000; src2 = 32'h0000BEEF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort.busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.result", 64'(result), 64'(0));
        check("abort.outs",
              64'({zero, cout, ovf, busy, done, s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}),
              64'(0));
        rst = 1'b0;
        n_done = 0;
        repeat (2 * W + 4) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort.no_done", 64'(n_done), 64'(0));
        run_check("after_abort", vecs[7].code, vecs[7].a, vecs[7].b, 1'b0, vecs[7].e);

        // Randomised operations against the word-level model
        for (int k = 0; k < 40; k++) begin
            logic [3:0]   code;
            logic [W-1:0] a, b;
            code = codes[$urandom_range(0, 6)];
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 4) == 0) b = a;
            if ($urandom_range(0, 4) == 0) a = {1'b1, {(W-1){1'b0}}};
            e = model(code, a, b);
            run_check($sformatf("rand%0d", k), code, a, b, 1'b0, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that drives the operand/control side of a single combinational 1-bit ALU slice, one bit per cycle, LSB first.
- Accepts a 32-bit operation with a start/done handshake and feeds carry back between bits.
- Assembles the result word and produces zero, cout and overflow flags.
- Sits between the datapath and an external 1-bit slice; the slice is not instantiated inside this block.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 2..64).

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request pulse; sampled only in IDLE.
- src1_i  input  WIDTH  operand A, latched on an accepted start.
- src2_i  input  WIDTH  operand B, latched on an accepted start.
- ALU_control_i  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT.
- slice_src1_o  output  1  current bit of A.
- slice_src2_o  output  1  current bit of B.
- slice_less_o  output  1  less input for the current bit.
- slice_A_invert_o  output  1  invert A at the slice.
- slice_B_invert_o  output  1  invert B at the slice.
- slice_cin_o  output  1  carry into the current bit.
- slice_operation_o  output  2  slice op: 00 AND, 01 OR, 10 ADD, 11 LESS.
- slice_result_i  input  1  combinational slice result, same cycle.
- slice_cout_i  input  1  combinational slice carry out, same cycle.
- result_o  output  WIDTH  assembled result; held until the next accepted start.
- zero_o  output  1  result_o equals 0.
- cout_o  output  1  carry out of the MSB (ADD/SUB only, else 0).
- overflow_o  output  1  signed overflow (ADD/SUB only, else 0).
- busy_o  output  1  high from the cycle after an accepted start until done.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state to IDLE; all registers and all outputs to 0.
  - zero_o resets to 0, not 1.
  - Reset mid-operation aborts with no done_o pulse.
  - Reset has priority over start_i.
- States: IDLE, RUN, SLT_RUN, DONE.
- IDLE:
  - On start_i=1, latch operands and ALU_control_i, bit index to 0, carry register to B_invert.
  - Valid code: go to RUN.
  - Invalid code: go to DONE, with result 0, zero 1, cout 0, overflow 0.
- start_i outside IDLE is ignored; no queuing.
- Slice control decode:
  - AND: op 00, Ainv 0, Binv 0.
  - OR: op 01, Ainv 0, Binv 0.
  - ADD: op 10, Ainv 0, Binv 0.
  - SUB: op 10, Ainv 0, Binv 1.
  - NOR: op 00, Ainv 1, Binv 1.
  - SLT first pass: op 10, Ainv 0, Binv 1.
- RUN, at each cycle with bit index i:
  - Drive src1[i], src2[i], slice_cin_o = carry register, slice_less_o = 0.
  - Capture slice_result_i into result bit i (except SLT pass 1) and slice_cout_i into the carry register.
  - At i=WIDTH-1, record cin_msb = slice_cin_o and cout_msb = slice_cout_i.
  - After the last bit: go to DONE, or to SLT_RUN for SLT.
- SLT pass 1 leaves the result unwritten.
  - set = sum[WIDTH-1] XOR (cin_msb XOR cout_msb), i.e. signed less-than.
- SLT_RUN: WIDTH cycles.
  - op 11, Ainv 0, Binv 1; carry chain as in pass 1.
  - slice_less_o = set at bit 0, 0 at all other bits.
  - Result bits come from slice_result_i.
- DONE: one cycle.
  - done_o=1, busy_o=0.
  - zero_o, cout_o, overflow_o updated together with result_o. For ADD/SUB: cout = cout_msb, overflow = cin_msb XOR cout_msb.
  - Go to IDLE; a start_i seen in DONE is ignored.
- Latency, with start accepted at edge T:
  - done_o high during cycle T+WIDTH+1, or T+2*WIDTH+1 for SLT.
  - Invalid code: done_o high during cycle T+1.
- Slice outputs are all 0 in IDLE and DONE.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB is never written into result_o.

Decomposition:
- Shared package alu_pkg:
  - ALU_control code constants (AND, OR, ADD, SUB, NOR, SLT).
  - Slice op constants (00/01/10/11).
  - State encoding.
- One natural sub-module, alu_ctrl_decode: combinational, ALU_control to {slice_operation, A_invert, B_invert, needs_slt_pass, valid}.
- Bench pairs the block with a reference 1-bit slice model.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, done at T+33.
- SUB 0x00000005 - 0x00000005 -> result 0, zero 1, cout 1, overflow 0.
- SLT 0xFFFFFFFF (-1) vs 0x00000001 -> result 0x00000001, done at T+65; swapped operands -> result 0.
- NOR 0x0F0F0F0F, 0x00FF00FF -> 0xF000F000; invalid code 1111 -> done at T+1, result 0, zero 1.
- start_i held high through RUN -> exactly one done_o pulse, operands unchanged. rst_i at bit 10 -> all outputs 0 next cycle, no done_o, new start then works.
